// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-port round-robin arbiter in front of a single
// line-granular memory channel, one transaction outstanding at a time.
//
// Ports:
//   clk_in, rst_N_in               rising-edge clock, async active-low reset
//   reqN_valid/addr/we/data_in     requester N request (held until ready)
//   reqN_ready_out                 one-cycle grant pulse to requester N
//   rspN_valid/addr/data_out       one-cycle read response to requester N
//   lc_valid/addr/value_out, we_out, lc_ready_in   downstream request channel
//   lc_valid/addr/value_in, lc_ready_out           downstream response channel
//   grantN_cnt_out                 per-port grant counters
//
// Optional feature: define MEM_REQ_ARBITER_STATS_EN to build the grant
// counters; otherwise grantN_cnt_out read 0.
module mem_req_arbiter #(
  parameter int unsigned B         = 64,
  parameter int unsigned ADDR_BITS = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,

  input  logic                 req0_valid_in,
  input  logic [ADDR_BITS-1:0] req0_addr_in,
  input  logic                 req0_we_in,
  input  logic [B*8-1:0]       req0_data_in,
  input  logic                 req1_valid_in,
  input  logic [ADDR_BITS-1:0] req1_addr_in,
  input  logic                 req1_we_in,
  input  logic [B*8-1:0]       req1_data_in,
  output logic                 req0_ready_out,
  output logic                 req1_ready_out,

  output logic                 rsp0_valid_out,
  output logic [ADDR_BITS-1:0] rsp0_addr_out,
  output logic [B*8-1:0]       rsp0_data_out,
  output logic                 rsp1_valid_out,
  output logic [ADDR_BITS-1:0] rsp1_addr_out,
  output logic [B*8-1:0]       rsp1_data_out,

  output logic                 lc_valid_out,
  output logic [ADDR_BITS-1:0] lc_addr_out,
  output logic [B*8-1:0]       lc_value_out,
  output logic                 we_out,
  input  logic                 lc_ready_in,

  input  logic                 lc_valid_in,
  input  logic [ADDR_BITS-1:0] lc_addr_in,
  input  logic [B*8-1:0]       lc_value_in,
  output logic                 lc_ready_out,

  output logic [31:0]          grant0_cnt_out,
  output logic [31:0]          grant1_cnt_out
);

  localparam int unsigned DATA_BITS = B * 8;
  // Clears the byte-offset bits of an address (B is a power of two).
  localparam logic [ADDR_BITS-1:0] LINE_MASK = ~(ADDR_BITS'(B) - ADDR_BITS'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

  state_t                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic                   owner_q, owner_d;
  logic [ADDR_BITS-1:0]   cap_addr_q, cap_addr_d;
  logic                   cap_we_q, cap_we_d;
  logic [DATA_BITS-1:0]   cap_data_q, cap_data_d;
  logic [ADDR_BITS-1:0]   rsp0_addr_d, rsp1_addr_d;
  logic [DATA_BITS-1:0]   rsp0_data_d, rsp1_data_d;
  logic                   winner_c;
  logic                   grant0_c, grant1_c;
  logic                   line_hit_c;

  // Response belongs to the outstanding request only if the line matches.
  assign line_hit_c = ((lc_addr_in ^ cap_addr_q) & LINE_MASK) == '0;

  // State register.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cap_addr_d  = cap_addr_q;
    cap_we_d    = cap_we_q;
    cap_data_d  = cap_data_q;
    rsp0_addr_d = rsp0_addr_out;
    rsp0_data_d = rsp0_data_out;
    rsp1_addr_d = rsp1_addr_out;
    rsp1_data_d = rsp1_data_out;
    winner_c    = 1'b0;
    grant0_c    = 1'b0;
    grant1_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid_in || req1_valid_in) begin
          // Contention goes to the priority port; priority then moves to the loser.
          winner_c   = (req0_valid_in && req1_valid_in) ? prio_q : req1_valid_in;
          owner_d    = winner_c;
          prio_d     = ~winner_c;
          grant0_c   = ~winner_c;
          grant1_c   = winner_c;
          cap_addr_d = winner_c ? req1_addr_in : req0_addr_in;
          cap_we_d   = winner_c ? req1_we_in   : req0_we_in;
          cap_data_d = winner_c ? req1_data_in : req0_data_in;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (lc_ready_in) state_d = cap_we_q ? IDLE : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (lc_valid_in && line_hit_c) begin
          state_d = RESPOND;
          if (owner_q) begin
            rsp1_addr_d = cap_addr_q;
            rsp1_data_d = lc_value_in;
          end else begin
            rsp0_addr_d = cap_addr_q;
            rsp0_data_d = lc_value_in;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs, derived from the next state.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      cap_addr_q     <= '0;
      cap_we_q       <= 1'b0;
      cap_data_q     <= '0;
      req0_ready_out <= 1'b0;
      req1_ready_out <= 1'b0;
      lc_valid_out   <= 1'b0;
      we_out         <= 1'b0;
      lc_addr_out    <= '0;
      lc_value_out   <= '0;
      lc_ready_out   <= 1'b0;
      rsp0_valid_out <= 1'b0;
      rsp1_valid_out <= 1'b0;
      rsp0_addr_out  <= '0;
      rsp0_data_out  <= '0;
      rsp1_addr_out  <= '0;
      rsp1_data_out  <= '0;
    end else begin
      prio_q         <= prio_d;
      owner_q        <= owner_d;
      cap_addr_q     <= cap_addr_d;
      cap_we_q       <= cap_we_d;
      cap_data_q     <= cap_data_d;
      req0_ready_out <= grant0_c;
      req1_ready_out <= grant1_c;
      lc_valid_out   <= (state_d == ISSUE);
      we_out         <= (state_d == ISSUE) && cap_we_d;
      lc_addr_out    <= cap_addr_d & LINE_MASK;
      lc_value_out   <= cap_data_d;
      lc_ready_out   <= (state_d == WAIT_RSP);
      rsp0_valid_out <= (state_d == RESPOND) && !owner_d;
      rsp1_valid_out <= (state_d == RESPOND) && owner_d;
      rsp0_addr_out  <= rsp0_addr_d;
      rsp0_data_out  <= rsp0_data_d;
      rsp1_addr_out  <= rsp1_addr_d;
      rsp1_data_out  <= rsp1_data_d;
    end
  end

`ifdef MEM_REQ_ARBITER_STATS_EN
  // Per-port grant counters, wrapping modulo 2^32.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      grant0_cnt_out <= '0;
      grant1_cnt_out <= '0;
    end else begin
      if (grant0_c) grant0_cnt_out <= grant0_cnt_out + 32'd1;
      if (grant1_c) grant1_cnt_out <= grant1_cnt_out + 32'd1;
    end
  end
`else
  assign grant0_cnt_out = '0;
  assign grant1_cnt_out = '0;
`endif

endmodule
